// File: rtl/mem_ctl_pipe.sv
// Word-addressed memory controller with a fixed-latency read pipeline and a refresh stall FSM.
// Optional address trap flag/counter enabled by defining MEM_CTL_ADDR_TRAP_EN.
module mem_ctl_pipe #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 22,
    parameter int DEPTH          = 4096,
    parameter int READ_LATENCY   = 1,
    parameter int REFRESH_CYCLES = 4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_ERR = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mem_req_rd_cmd,
    input  logic [ADDR_WIDTH-1:0] mem_req_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_req_rd_dta,
    output logic                  mem_req_rd_en,
    input  logic                  mem_req_rd_valid,
    output logic [DATA_WIDTH-1:0] mem_res_wr_dta,
    output logic                  mem_res_wr_en,
    input  logic                  mem_res_wr_almost_full,
    output logic                  addr_err,
    output logic [7:0]            addr_err_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [7:0] REFRESH_LOAD = 8'(REFRESH_CYCLES);
    localparam logic [1:0] CMD_REFRESH = 2'd1;
    localparam logic [1:0] CMD_READ    = 2'd2;
    localparam logic [1:0] CMD_WRITE   = 2'd3;
`ifdef MEM_CTL_ADDR_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic {ST_RUN, ST_REFRESH} state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q, state_d;
    logic [7:0]            stall_cnt_q, stall_cnt_d;
    logic                  rd_en_q, rd_en_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_WIDTH-1:0] pipe_dta_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_dta_d [READ_LATENCY];
    logic                  addr_err_q, addr_err_d;
    logic [7:0]            addr_err_cnt_q, addr_err_cnt_d;

    logic             accept, in_range, is_read, is_write, is_refresh, mem_we, trap;
    logic [IDX_W-1:0] idx;

    // Acceptance ignores mem_req_rd_en: the upstream FIFO is trusted to honour it.
    assign accept     = mem_req_rd_valid & ~rst;
    assign in_range   = ({1'b0, mem_req_rd_addr} < DEPTH_X);
    assign idx        = mem_req_rd_addr[IDX_W-1:0];
    assign is_read    = accept & (mem_req_rd_cmd == CMD_READ);
    assign is_write   = accept & (mem_req_rd_cmd == CMD_WRITE);
    assign is_refresh = accept & (mem_req_rd_cmd == CMD_REFRESH);
    assign mem_we     = is_write & in_range;
    assign trap       = TRAP_EN & (is_read | is_write) &
                        ((mem_req_rd_addr == ADDR_ERR) | ~in_range);

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (is_refresh) begin
                    state_d     = ST_REFRESH;
                    stall_cnt_d = REFRESH_LOAD;
                end
            end
            ST_REFRESH: begin
                if (is_refresh) begin
                    stall_cnt_d = REFRESH_LOAD;
                end else begin
                    stall_cnt_d = stall_cnt_q - 8'd1;
                    if (stall_cnt_q == 8'd1) state_d = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_RUN;
                stall_cnt_d = 8'd0;
            end
        endcase
        // Enable tracks the next state so the stall window covers exactly the counted cycles.
        rd_en_d = (state_d == ST_RUN) & ~mem_res_wr_almost_full;
    end

    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_vld_d[0] = is_read;
        pipe_dta_d[0] = (is_read & in_range) ? mem_q[idx] : '0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_dta_d[i] = pipe_dta_q[i-1];
        end
    end

    always_comb begin
        addr_err_d     = addr_err_q | trap;
        addr_err_cnt_d = addr_err_cnt_q;
        if (trap && addr_err_cnt_q != 8'd255) addr_err_cnt_d = addr_err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            stall_cnt_q    <= 8'd0;
            rd_en_q        <= 1'b0;
            pipe_vld_q     <= '0;
            addr_err_q     <= 1'b0;
            addr_err_cnt_q <= 8'd0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_dta_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            stall_cnt_q    <= stall_cnt_d;
            rd_en_q        <= rd_en_d;
            pipe_vld_q     <= pipe_vld_d;
            addr_err_q     <= addr_err_d;
            addr_err_cnt_q <= addr_err_cnt_d;
            for (int i = 0; i < READ_LATENCY; i++) pipe_dta_q[i] <= pipe_dta_d[i];
        end
    end

    // Storage is not reset so contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= mem_req_rd_dta;
    end

    assign mem_req_rd_en  = rd_en_q;
    assign mem_res_wr_en  = pipe_vld_q[READ_LATENCY-1];
    assign mem_res_wr_dta = pipe_dta_q[READ_LATENCY-1];
    assign addr_err       = addr_err_q;
    assign addr_err_cnt   = addr_err_cnt_q;

endmodule

// File: tb/tb_mem_ctl_pipe.sv
// Scoreboard bench for mem_ctl_pipe: READ_LATENCY=3, REFRESH_CYCLES=4, default widths/depth.
module tb_mem_ctl_pipe;

  localparam int DW    = 64;
  localparam int AW    = 22;
  localparam int DEPTH = 4096;
  localparam int RL    = 3;
  localparam int RC    = 4;
  localparam logic [AW-1:0] AERR = '1;
  localparam logic [1:0] C_NOOP = 2'd0, C_REFRESH = 2'd1, C_READ = 2'd2, C_WRITE = 2'd3;
`ifdef MEM_CTL_ADDR_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cmd_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] dta_i;
  logic          valid_i;
  logic          af_i;
  logic          rd_en;
  logic [DW-1:0] res_dta;
  logic          res_en;
  logic          addr_err;
  logic [7:0]    addr_err_cnt;

  logic [DW-1:0] exp_q[$];
  int            exp_t_q[$];
  logic [DW-1:0] model [int];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  bit            exp_err = 1'b0;
  int            exp_err_cnt = 0;

  mem_ctl_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(RL), .REFRESH_CYCLES(RC)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_req_rd_cmd         (cmd_i),
    .mem_req_rd_addr        (addr_i),
    .mem_req_rd_dta         (dta_i),
    .mem_req_rd_en          (rd_en),
    .mem_req_rd_valid       (valid_i),
    .mem_res_wr_dta         (res_dta),
    .mem_res_wr_en          (res_en),
    .mem_res_wr_almost_full (af_i),
    .addr_err               (addr_err),
    .addr_err_cnt           (addr_err_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [1:0] cmd, input logic [AW-1:0] addr, input logic [DW-1:0] dta);
    @(posedge clk); #1;
    valid_i = 1'b1; cmd_i = cmd; addr_i = addr; dta_i = dta;
    if (cmd == C_READ) begin
      exp_q.push_back((addr < DEPTH) ? model[int'(addr)] : '0);
      exp_t_q.push_back(cyc + RL);
    end
    if (cmd == C_WRITE && addr < DEPTH) model[int'(addr)] = dta;
    if (TRAP && (cmd == C_READ || cmd == C_WRITE) && (addr == AERR || addr >= DEPTH)) begin
      exp_err = 1'b1;
      if (exp_err_cnt < 255) exp_err_cnt++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_i = 1'b0; cmd_i = C_NOOP;
    end
  endtask

  task automatic drain();
    repeat (20) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic refresh_window(input bit second, output int lows);
    drive(C_REFRESH, '0, '0);
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      if (second && i == 1) drive(C_REFRESH, '0, '0);
      else idle(1);
      @(negedge clk);
      if (!rd_en) lows++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({tag, "_res_en"}, 64'(res_en), 64'd0);
    chk({tag, "_res_dta"}, res_dta, 64'd0);
    chk({tag, "_addr_err"}, 64'(addr_err), 64'd0);
    chk({tag, "_err_cnt"}, 64'(addr_err_cnt), 64'd0);
  endtask

  // scoreboard: compare each response against the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      if (res_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'(res_en), 64'd0);
        end else begin
          chk("rd_data", res_dta, exp_q.pop_front());
          chk("rd_latency", 64'(cyc), 64'(exp_t_q.pop_front()));
        end
      end else begin
        chk("idle_dta_zero", res_dta, 64'd0);
      end
    end
  end

  initial begin
    int lows;
    logic [AW-1:0] ra;
    rst = 1'b1; valid_i = 1'b0; cmd_i = C_NOOP; addr_i = '0; dta_i = '0; af_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    @(negedge clk);
    chk("rd_en_after_reset", 64'(rd_en), 64'd1);

    // write then read next cycle, latency 3
    drive(C_WRITE, 22'd5, 64'h0123456789ABCDEF);
    drive(C_READ, 22'd5, '0);
    idle(1);
    drain();

    // back-to-back reads of 0..7
    for (int i = 0; i < 8; i++) drive(C_WRITE, AW'(i), DW'(i));
    for (int i = 0; i < 8; i++) drive(C_READ, AW'(i), '0);
    idle(1);
    drain();

    // refresh stall windows
    refresh_window(1'b0, lows);
    chk("refresh_low_single", 64'(lows), 64'd4);
    chk("refresh_end_rd_en", 64'(rd_en), 64'd1);
    refresh_window(1'b1, lows);
    chk("refresh_low_extended", 64'(lows), 64'd6);
    drive(C_REFRESH, '0, '0);
    drive(C_READ, 22'd3, '0);
    idle(1);
    drain();
    idle(6);

    // almost-full backpressure with reads in flight
    drive(C_READ, 22'd1, '0);
    drive(C_READ, 22'd2, '0);
    @(posedge clk); #1;
    valid_i = 1'b0; cmd_i = C_NOOP; af_i = 1'b1;
    @(negedge clk);
    chk("af_same_cycle", 64'(rd_en), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("af_next_cycle", 64'(rd_en), 64'd0);
    drain();
    @(posedge clk); #1;
    af_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("af_release", 64'(rd_en), 64'd1);

    // out-of-range read and trap counter saturation
    drive(C_READ, AW'(DEPTH + 1), '0);
    idle(1);
    drain();
    chk("trap_flag_first", 64'(addr_err), 64'(exp_err));
    chk("trap_cnt_first", 64'(addr_err_cnt), 64'(exp_err_cnt));
    for (int i = 0; i < 300; i++) drive(C_WRITE, (i % 2 == 1) ? AERR : AW'(DEPTH + i), DW'(i));
    idle(1);
    @(negedge clk);
    chk("trap_flag_many", 64'(addr_err), 64'(exp_err));
    chk("trap_cnt_saturate", 64'(addr_err_cnt), 64'(exp_err_cnt));
    drive(C_READ, 22'd5, '0);
    idle(1);
    drain();

    // random in-range traffic
    for (int i = 0; i < 40; i++) begin
      ra = AW'($urandom_range(100, 115));
      if (model.exists(int'(ra)) && $urandom_range(0, 1) == 1) drive(C_READ, ra, '0);
      else drive(C_WRITE, ra, {$urandom, $urandom});
    end
    idle(1);
    drain();

    // reset with reads in flight; command during reset is ignored
    drive(C_WRITE, 22'd20, 64'hAAAA_5555_0000_FFFF);
    drive(C_WRITE, 22'd21, 64'h1357_9BDF_2468_ACE0);
    idle(1);
    drain();
    drive(C_READ, 22'd20, '0);
    drive(C_READ, 22'd21, '0);
    @(posedge clk); #1;
    rst = 1'b1; valid_i = 1'b1; cmd_i = C_WRITE; addr_i = 22'd20; dta_i = 64'hDEAD_BEEF_DEAD_BEEF;
    exp_q.delete();
    exp_t_q.delete();
    @(posedge clk); #1;
    valid_i = 1'b0; cmd_i = C_NOOP;
    @(negedge clk);
    chk_reset_vals("midrst");
    exp_err = 1'b0;
    exp_err_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    drive(C_READ, 22'd20, '0);
    drive(C_READ, 22'd21, '0);
    idle(1);
    drain();
    chk("post_rst_flag", 64'(addr_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
